// File: rtl/vid_frame_ctrl.sv
// Frame-level controller for the PixelClk video path: checks input timing lock,
// debounces mode switches and switches mode/source only on frame boundaries.
module vid_frame_ctrl #(
  parameter int H_FRAME         = 1650,
  parameter int V_FRAME         = 750,
  parameter int LOCK_FRAMES     = 4,
  parameter int DEBOUNCE_CYCLES = 74250
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   sw,
  input  logic [$clog2(H_FRAME)-1:0]   in_hcnt,
  input  logic [$clog2(V_FRAME)-1:0]   in_vcnt,
  output logic [3:0]                   mode,
  output logic                         src_live,
  output logic                         locked,
  output logic                         frame_start,
  output logic [7:0]                   err_cnt
);

  localparam int HW  = $clog2(H_FRAME);
  localparam int VW  = $clog2(V_FRAME);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW  = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0]  H_LAST    = HW'(H_FRAME - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_FRAME - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]  LOCK_LAST = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t         state;
  logic [GW-1:0]  good;

  logic [3:0]     sw_meta;
  logic [3:0]     sw_sync;
  logic [3:0]     sw_cand;
  logic [3:0]     sw_db;
  logic [DBW-1:0] db_cnt;

  logic [HW-1:0]  prev_h;
  logic [VW-1:0]  prev_v;
  logic           prev_valid;
  logic [HW-1:0]  exp_h;
  logic [VW-1:0]  exp_v;
  logic           err;
  logic           fb;

  // Predict the next counter pair from the previous sample; the very first
  // sample after reset has nothing to compare against.
  always_comb begin
    exp_h = (prev_h == H_LAST) ? '0 : prev_h + 1'b1;
    exp_v = prev_v;
    if (prev_h == H_LAST) begin
      exp_v = (prev_v == V_LAST) ? '0 : prev_v + 1'b1;
    end
    err = prev_valid && ((in_hcnt != exp_h) || (in_vcnt != exp_v));
    fb  = (in_hcnt == '0) && (in_vcnt == '0);
  end

  // Switch synchroniser and debounce, timing tracker and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta     <= '0;
      sw_sync     <= '0;
      sw_cand     <= '0;
      sw_db       <= '0;
      db_cnt      <= '0;
      prev_h      <= '0;
      prev_v      <= '0;
      prev_valid  <= 1'b0;
      frame_start <= 1'b0;
      err_cnt     <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (sw_sync != sw_cand) begin
        sw_cand <= sw_sync;
        db_cnt  <= '0;
      end else if (db_cnt == DB_LAST) begin
        sw_db <= sw_cand;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      prev_h      <= in_hcnt;
      prev_v      <= in_vcnt;
      prev_valid  <= 1'b1;
      frame_start <= fb;
      if (err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  // Lock FSM. Errors drop to the fallback source immediately; going live and
  // mode changes while tracking wait for a frame boundary so no frame tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNLOCKED;
      good     <= '0;
      locked   <= 1'b0;
      src_live <= 1'b0;
      mode     <= '0;
    end else begin
      case (state)
        UNLOCKED: begin
          mode <= sw_db;
          if (fb && !err) begin
            state <= LOCKING;
            good  <= '0;
          end
        end
        LOCKING: begin
          if (err) begin
            state <= UNLOCKED;
          end else if (fb) begin
            mode <= sw_db;
            if (good == LOCK_LAST) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              src_live <= 1'b1;
            end else begin
              good <= good + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (err) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            src_live <= 1'b0;
          end else if (fb) begin
            mode <= sw_db;
          end
        end
        default: begin
          state    <= UNLOCKED;
          locked   <= 1'b0;
          src_live <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_frame_ctrl.sv
// Self-checking bench for vid_frame_ctrl with a small 16x8 frame so whole
// frames, lock sequences and error saturation run quickly.
module tb_vid_frame_ctrl;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int LF = 2;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic [3:0] in_hcnt = '0;
  logic [2:0] in_vcnt = '0;
  logic [3:0] mode;
  logic       src_live;
  logic       locked;
  logic       frame_start;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int h_c      = 0;
  int v_c      = 0;
  int err_exp  = 0;

  // Expected vector layout: {frame_start, locked, src_live, err_cnt[7:0], mode[3:0]}
  logic [14:0] exp_q[$];
  logic [14:0] act_v;
  logic [14:0] exp_e;
  logic [14:0] got;

  assign act_v = {frame_start, locked, src_live, err_cnt, mode};

  always #5 clk = ~clk;

  vid_frame_ctrl #(
    .H_FRAME(H), .V_FRAME(V), .LOCK_FRAMES(LF), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .in_hcnt(in_hcnt), .in_vcnt(in_vcnt),
    .mode(mode), .src_live(src_live), .locked(locked),
    .frame_start(frame_start), .err_cnt(err_cnt)
  );

  task automatic drive(input int h, input int v);
    in_hcnt = 4'(h);
    in_vcnt = 3'(v);
    @(negedge clk);
  endtask

  task automatic adv();
    if (h_c == H - 1) begin
      h_c = 0;
      v_c = (v_c == V - 1) ? 0 : v_c + 1;
    end else begin
      h_c = h_c + 1;
    end
  endtask

  function automatic logic [14:0] pk(input logic fs, input logic lk, input int ec, input int md);
    return {fs, lk, lk, 8'(ec), 4'(md)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sw  = 4'd0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pk(1'b0, 1'b0, 0, 0));
      drive(5, 3);
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL reset i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", i,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_lock();
    int nfb = 0;
    logic fb;
    rst = 1'b0;
    h_c = 0;
    v_c = 0;
    for (int i = 0; i < 2 * H * V + 4; i++) begin
      fb = (h_c == 0) && (v_c == 0);
      if (fb) nfb++;
      exp_q.push_back(pk(fb, nfb >= LF + 1, 0, 0));
      drive(h_c, v_c);
      adv();
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL lock i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", i,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_err_relock();
    int nfb = 0;
    int post = 0;
    logic bad = 1'b0;
    logic fb;
    for (int i = 0; i < 1000 && post < 3; i++) begin
      if (i == 2) begin
        adv();                       // skip one pixel count
        bad = 1'b1;
        err_exp = err_exp + 1;
      end
      fb = (h_c == 0) && (v_c == 0);
      if (bad && fb) nfb++;
      if (bad) exp_q.push_back(pk(fb, nfb >= LF + 1, err_exp, 0));
      else     exp_q.push_back(pk(fb, 1'b1, err_exp, 0));
      drive(h_c, v_c);
      adv();
      if (nfb >= LF + 1) post++;
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL err_relock i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", i,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_mode_change();
    logic fb;
    for (int ph = 0; ph < 2; ph++) begin
      int post = 0;
      logic seen = 1'b0;
      int m_old = (ph == 0) ? 0 : 5;
      int m_new = (ph == 0) ? 5 : 0;
      sw = 4'(m_new);
      for (int i = 0; i < 300 && post < 3; i++) begin
        fb = (h_c == 0) && (v_c == 0);
        if (fb) seen = 1'b1;
        exp_q.push_back(pk(fb, 1'b1, err_exp, seen ? m_new : m_old));
        drive(h_c, v_c);
        adv();
        if (seen) post++;
        got = act_v; exp_e = exp_q.pop_front(); n_checks++;
        if (got !== exp_e)
          $display("FAIL mode_change ph=%0d i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", ph, i,
                   got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sw_glitch();
    int post = 0;
    logic seen = 1'b0;
    logic fb;
    for (int i = 0; i < 300 && post < 3; i++) begin
      sw = (i >= 10 && i < 13) ? 4'd3 : 4'd0;
      fb = (h_c == 0) && (v_c == 0);
      if (fb) seen = 1'b1;
      exp_q.push_back(pk(fb, 1'b1, err_exp, 0));
      drive(h_c, v_c);
      adv();
      if (seen) post++;
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL sw_glitch i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", i,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    // The first held sample is still the correct next count; every later one is an error.
    for (int i = 0; i < 300; i++) begin
      if (i > 0 && err_exp < 255) err_exp = err_exp + 1;
      exp_q.push_back(pk(1'b0, i == 0, err_exp, 0));
      drive(h_c, v_c);
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL saturate i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", i,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_unlocked_mode();
    for (int ph = 0; ph < 2; ph++) begin
      sw = (ph == 0) ? 4'd6 : 4'd0;
      exp_q.push_back(pk(1'b0, 1'b0, 255, (ph == 0) ? 6 : 0));
      for (int i = 0; i < 12; i++) drive(h_c, v_c);
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL unlocked_mode ph=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", ph,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    int nfb = 0;
    int post = 0;
    logic fb;
    adv();
    for (int i = 0; i < 1000 && post < 40; i++) begin
      fb = (h_c == 0) && (v_c == 0);
      if (fb) nfb++;
      exp_q.push_back(pk(fb, nfb >= LF + 1, err_exp, 0));
      drive(h_c, v_c);
      adv();
      if (nfb >= LF + 1) post++;
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL rst_prelock i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", i,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
    rst = 1'b1;
    err_exp = 0;
    exp_q.push_back(pk(1'b0, 1'b0, 0, 0));
    drive(h_c, v_c);
    adv();
    rst = 1'b0;
    got = act_v; exp_e = exp_q.pop_front(); n_checks++;
    if (got !== exp_e)
      $display("FAIL rst_pulse act=%b/%0d/%0d exp=%b/%0d/%0d",
               got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
    else n_pass++;
    nfb = 0;
    post = 0;
    for (int i = 0; i < 1000 && post < 3; i++) begin
      fb = (h_c == 0) && (v_c == 0);
      if (fb) nfb++;
      exp_q.push_back(pk(fb, nfb >= LF + 1, 0, 0));
      drive(h_c, v_c);
      adv();
      if (nfb >= LF + 1) post++;
      got = act_v; exp_e = exp_q.pop_front(); n_checks++;
      if (got !== exp_e)
        $display("FAIL rst_relock i=%0d act=%b/%0d/%0d exp=%b/%0d/%0d", i,
                 got[14:12], got[11:4], got[3:0], exp_e[14:12], exp_e[11:4], exp_e[3:0]);
      else n_pass++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lock();
    test_err_relock();
    test_mode_change();
    test_sw_glitch();
    test_saturate();
    test_unlocked_mode();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
